// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a data-cache port and an instruction-cache port onto one line-wide data memory.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default build uses fixed priority (port 0 wins).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

  state_t              state_reg;
  logic                owner_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                p0_ack_reg;
  logic                p1_ack_reg;
  logic [1:0]          grant_reg;
  logic                busy_reg;
  logic                mem_enable_reg;
  logic                mem_write_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [DATA_W-1:0]   mem_data_reg;

  logic any_req;
  logic winner;   // 0 = port 0, 1 = port 1; only meaningful when any_req

  assign any_req = p0_enable_i | p1_enable_i;

`ifdef MEM_ARBITER_RR_EN
  logic last_reg;

  always_comb begin
    winner = p1_enable_i;
    if (p0_enable_i && p1_enable_i)
      winner = ~last_reg;
  end

  // Pointer resets to port 1 so that port 0 is served first after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      last_reg <= 1'b1;
    else if (state_reg == IDLE && any_req)
      last_reg <= winner;
  end
`else
  assign winner = ~p0_enable_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      rdata_reg      <= '0;
      p0_ack_reg     <= 1'b0;
      p1_ack_reg     <= 1'b0;
      grant_reg      <= 2'b00;
      busy_reg       <= 1'b0;
      mem_enable_reg <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
    end else begin
      p0_ack_reg <= 1'b0;
      p1_ack_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg      <= BUSY;
            busy_reg       <= 1'b1;
            owner_reg      <= winner;
            grant_reg      <= winner ? 2'b10 : 2'b01;
            mem_enable_reg <= 1'b1;
            mem_write_reg  <= winner ? p1_write_i : p0_write_i;
            mem_addr_reg   <= winner ? p1_addr_i  : p0_addr_i;
            mem_data_reg   <= winner ? p1_data_i  : p0_data_i;
          end
        end
        BUSY: begin
          // Request lines are deliberately not looked at here; the latched copy drives memory.
          if (mem_ack_i) begin
            state_reg      <= RESP;
            mem_enable_reg <= 1'b0;
            p0_ack_reg     <= ~owner_reg;
            p1_ack_reg     <= owner_reg;
            if (!mem_write_reg)
              rdata_reg <= mem_data_i;
          end
        end
        RESP: begin
          state_reg <= GAP;
          grant_reg <= 2'b00;
        end
        GAP: begin
          // One dead cycle so the served port can drop its enable before re-arbitration.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign p0_ack_o     = p0_ack_reg;
  assign p1_ack_o     = p1_ack_reg;
  assign p0_data_o    = rdata_reg;
  assign p1_data_o    = rdata_reg;
  assign mem_enable_o = mem_enable_reg;
  assign mem_write_o  = mem_write_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_data_o   = mem_data_reg;
  assign busy_o       = busy_reg;
  assign grant_o      = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, directed corner sequences and randomized traffic
// checked against a transaction-level model of the two-port memory arbiter.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          p0_enable, p0_write, p1_enable, p1_write;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack_o, p1_ack_o;
  logic [DW-1:0] p0_data_o, p1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy_o;
  logic [1:0]    grant_o;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .p0_enable_i(p0_enable), .p0_write_i(p0_write), .p0_addr_i(p0_addr), .p0_data_i(p0_wdata),
    .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
    .p1_enable_i(p1_enable), .p1_write_i(p1_write), .p1_addr_i(p1_addr), .p1_data_i(p1_wdata),
    .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack), .mem_data_i(mem_rdata),
    .busy_o(busy_o), .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  typedef struct {
    logic          r0; logic w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic          r1; logic w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    int            lat; logic [DW-1:0] line;
    int            exp_port; logic [DW-1:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic get_ack(input int p);
    return (p == 0) ? p0_ack_o : p1_ack_o;
  endfunction

  // Arbitration rule expressed directly: who wins among the ports currently asking.
  function automatic int pick(input logic r0, input logic r1, input int last);
    if (r0 && r1) return RR ? 1 - last : 0;
    return r0 ? 0 : 1;
  endfunction

  task automatic set_req(input int p, input logic en, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      p0_enable = en; p0_write = wr; p0_addr = a; p0_wdata = d;
    end else begin
      p1_enable = en; p1_write = wr; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    int waited, t0, p;
    logic [AW-1:0] ea;
    logic ew;
    logic [DW-1:0] ed;
    p  = v.exp_port;
    ea = (p == 1) ? v.a1 : v.a0;
    ew = (p == 1) ? v.w1 : v.w0;
    ed = (p == 1) ? v.d1 : v.d0;
    set_req(0, v.r0, v.w0, v.a0, v.d0);
    set_req(1, v.r1, v.w1, v.a1, v.d1);
    t0 = cyc;
    waited = 0;
    do begin tick(); waited++; end while (mem_enable_o !== 1'b1 && waited < 20);
    chk_int("vec_req_to_busy", waited, 1);
    chk("vec_mem_addr", DW'(mem_addr_o), DW'(ea));
    chk("vec_mem_write", DW'(mem_write_o), DW'(ew));
    chk("vec_mem_data", mem_data_o, ed);
    chk("vec_grant", DW'(grant_o), DW'((p == 1) ? 2'b10 : 2'b01));
    chk("vec_busy", DW'(busy_o), DW'(1'b1));
    repeat (v.lat) tick();
    chk("vec_enable_held", DW'(mem_enable_o), DW'(1'b1));
    mem_ack = 1'b1; mem_rdata = v.line;
    tick();
    mem_ack = 1'b0; mem_rdata = rand_line();
    chk("vec_ack_owner", DW'(get_ack(p)), DW'(1'b1));
    chk("vec_ack_other", DW'(get_ack(1 - p)), DW'(1'b0));
    chk_int("vec_ack_latency", cyc - t0, 2 + v.lat);
    chk("vec_p0_rdata", p0_data_o, v.exp_rd);
    chk("vec_p1_rdata", p1_data_o, v.exp_rd);
    chk("vec_enable_drop", DW'(mem_enable_o), DW'(1'b0));
    p0_enable = 1'b0; p1_enable = 1'b0;
    tick();
    chk("vec_ack_one_pulse", DW'({p0_ack_o, p1_ack_o}), DW'(2'b00));
    chk("vec_grant_gap", DW'(grant_o), DW'(2'b00));
    tick();
    $display("vec %0d port=%0d write=%0d addr=%h lat=%0d", idx, p, ew, ea, v.lat);
  endtask

  task automatic random_phase(input int ncyc);
    logic pend[2];
    logic pw[2];
    logic [AW-1:0] pa[2];
    logic [DW-1:0] pd[2];
    logic [DW-1:0] rd_model, mline;
    int last, owner, wait_c, idle_c, just, exp, ntx;
    bit in_txn, resp_next, stop;
    pend = '{1'b0, 1'b0}; pw = '{1'b0, 1'b0};
    rd_model = '0; last = 1; owner = 0; wait_c = 0; idle_c = 0; ntx = 0;
    in_txn = 0; resp_next = 0; stop = 0;
    for (int c = 0; c < ncyc && !stop; c++) begin
      tick();
      just = -1;
      if (resp_next) begin
        chk("rnd_ack_owner", DW'(get_ack(owner)), DW'(1'b1));
        chk("rnd_ack_other", DW'(get_ack(1 - owner)), DW'(1'b0));
        chk("rnd_p0_rdata", p0_data_o, rd_model);
        chk("rnd_p1_rdata", p1_data_o, rd_model);
        chk("rnd_enable_drop", DW'(mem_enable_o), DW'(1'b0));
        $display("rnd txn %0d port=%0d write=%0d addr=%h", ntx, owner, pw[owner], pa[owner]);
        ntx++;
        pend[owner] = 1'b0;
        set_req(owner, 1'b0, 1'b0, '0, '0);
        just = owner; resp_next = 0; in_txn = 0;
      end else begin
        chk("rnd_no_stray_ack", DW'({p0_ack_o, p1_ack_o}), DW'(2'b00));
      end
      if (!in_txn && mem_enable_o === 1'b1) begin
        exp = pick(pend[0], pend[1], last);
        chk("rnd_grant_had_request", DW'(pend[0] | pend[1]), DW'(1'b1));
        chk("rnd_mem_addr", DW'(mem_addr_o), DW'(pa[exp]));
        chk("rnd_mem_write", DW'(mem_write_o), DW'(pw[exp]));
        chk("rnd_mem_data", mem_data_o, pd[exp]);
        chk("rnd_grant", DW'(grant_o), DW'((exp == 1) ? 2'b10 : 2'b01));
        last = exp; owner = exp; in_txn = 1; idle_c = 0;
        wait_c = $urandom_range(0, 4);
      end
      mem_ack = 1'b0; mem_rdata = rand_line();
      if (in_txn && !resp_next) begin
        chk("rnd_busy_stable", DW'({mem_enable_o, mem_addr_o}), DW'({1'b1, pa[owner]}));
        // Scramble the owner's request fields: the arbiter must keep using its latched copy.
        set_req(owner, 1'b1, 1'($urandom), $urandom, rand_line());
        if (wait_c == 0) begin
          mline = rand_line();
          mem_ack = 1'b1; mem_rdata = mline;
          if (!pw[owner]) rd_model = mline;
          resp_next = 1;
        end else begin
          wait_c--;
        end
      end else if (!in_txn && $urandom_range(0, 5) == 0) begin
        mem_ack = 1'b1; mem_rdata = {DW{1'b1}};
      end
      if ((pend[0] || pend[1]) && !in_txn) begin
        idle_c++;
        if (idle_c > 6) begin
          chk_int("rnd_grant_timeout", idle_c, 0);
          stop = 1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && p != just && $urandom_range(0, 3) == 0) begin
          pend[p] = 1'b1;
          pw[p] = 1'($urandom);
          pa[p] = $urandom;
          pd[p] = rand_line();
          set_req(p, 1'b1, pw[p], pa[p], pd[p]);
        end
      end
    end
    mem_ack = 1'b0;
  endtask

  vec_t vecs[6];
  int   ord[4];

  initial begin
    int waited, w;
    logic [DW-1:0] keep;

    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);

    vecs[0] = '{1'b1, 1'b0, 32'h400, {DW{1'b0}}, 1'b0, 1'b0, 32'h0, {DW{1'b0}},
                4, {32{8'hA5}}, 0, {32{8'hA5}}};
    vecs[1] = '{1'b0, 1'b0, 32'h0, {DW{1'b0}}, 1'b1, 1'b1, 32'h800, 256'h1234,
                2, {32{8'h77}}, 1, {32{8'hA5}}};
    vecs[2] = '{1'b1, 1'b0, 32'h10, {DW{1'b0}}, 1'b1, 1'b0, 32'h20, {DW{1'b0}},
                0, {32{8'h11}}, 0, {32{8'h11}}};
    vecs[3] = '{1'b1, 1'b0, 32'h14, {DW{1'b0}}, 1'b1, 1'b0, 32'h24, {DW{1'b0}},
                1, {32{8'h22}}, 0, {32{8'h22}}};
    vecs[3].exp_port = RR ? 1 : 0;
    vecs[4] = '{1'b0, 1'b0, 32'h0, {DW{1'b0}}, 1'b1, 1'b0, 32'h30, {DW{1'b0}},
                3, {32{8'h33}}, 1, {32{8'h33}}};
    vecs[5] = '{1'b1, 1'b1, 32'h44, {8{32'hDEADBEEF}}, 1'b0, 1'b0, 32'h0, {DW{1'b0}},
                0, {32{8'h44}}, 0, {32{8'h33}}};

    // Reset state
    repeat (2) tick();
    chk("rst_mem_enable", DW'(mem_enable_o), DW'(1'b0));
    chk("rst_mem_write", DW'(mem_write_o), DW'(1'b0));
    chk("rst_mem_addr", DW'(mem_addr_o), DW'(0));
    chk("rst_mem_data", mem_data_o, '0);
    chk("rst_acks", DW'({p0_ack_o, p1_ack_o}), DW'(2'b00));
    chk("rst_rdata", p0_data_o, '0);
    chk("rst_busy_grant", DW'({busy_o, grant_o}), DW'(3'b000));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

    // Spurious memory ack while idle must change nothing
    keep = vecs[5].exp_rd;
    mem_ack = 1'b1; mem_rdata = {DW{1'b1}};
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("spur_no_ack", DW'({p0_ack_o, p1_ack_o}), DW'(2'b00));
      chk("spur_rdata", p0_data_o, keep);
      chk("spur_busy", DW'(busy_o), DW'(1'b0));
      tick();
    end
    $display("spurious ack in idle applied");

    // Reset in the middle of a memory transaction
    set_req(0, 1'b1, 1'b0, 32'h600, '0);
    waited = 0;
    do begin tick(); waited++; end while (mem_enable_o !== 1'b1 && waited < 20);
    chk_int("abort_req_to_busy", waited, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_enable_now", DW'(mem_enable_o), DW'(1'b0));
    chk("abort_busy_now", DW'({busy_o, grant_o}), DW'(3'b000));
    p0_enable = 1'b0;
    @(negedge clk); cyc++;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = {DW{1'b1}};
    tick();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("abort_no_ack", DW'({p0_ack_o, p1_ack_o}), DW'(2'b00));
      chk("abort_idle", DW'({busy_o, mem_enable_o}), DW'(2'b00));
      chk("abort_rdata_cleared", p0_data_o, '0);
      tick();
    end
    $display("reset during busy applied");

    // Both ports held high for several rounds
    ord = RR ? '{0, 1, 0, 1} : '{0, 0, 0, 1};
    set_req(0, 1'b1, 1'b0, 32'h100, '0);
    set_req(1, 1'b1, 1'b0, 32'h200, '0);
    for (int r = 0; r < 4; r++) begin
      waited = (r == 0) ? 0 : 1;
      do begin tick(); waited++; end while (mem_enable_o !== 1'b1 && waited < 20);
      chk_int("rounds_wait", waited, (r == 0) ? 1 : 3);
      w = (mem_addr_o == 32'h200) ? 1 : 0;
      chk_int("rounds_winner", w, ord[r]);
      mem_ack = 1'b1; mem_rdata = {8{mem_addr_o}};
      tick();
      mem_ack = 1'b0;
      chk("rounds_ack", DW'({p1_ack_o, p0_ack_o}), DW'((ord[r] == 1) ? 2'b10 : 2'b01));
      chk("rounds_rdata", p0_data_o, {8{(ord[r] == 1) ? 32'h200 : 32'h100}});
      $display("round %0d served port=%0d", r, w);
      set_req(w, 1'b0, 1'b0, (w == 1) ? 32'h200 : 32'h100, '0);
      tick();
      if (r < 2) set_req(w, 1'b1, 1'b0, (w == 1) ? 32'h200 : 32'h100, '0);
    end
    repeat (3) tick();
    chk("rounds_idle_after", DW'({busy_o, mem_enable_o}), DW'(2'b00));

    // Fresh reset, then randomized traffic against the model
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    random_phase(1500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
